uart_mult_byte_tx: RTL and testbench

UART_MULT_BYTE_TX -- requirements
Module: uart_mult_byte_tx

---
 rtl/uart_mult_byte_tx_pkg.sv | 17 +
 rtl/uart_mult_byte_tx_byte.sv | 74 +++++++
 rtl/uart_mult_byte_tx.sv | 87 ++++++++
 tb/tb_uart_mult_byte_tx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mult_byte_tx_pkg.sv
// Frame constants and serialiser state encoding shared by the multi-byte UART
// transmitter and its matching receiver.
package uart_mult_byte_tx_pkg;

    localparam int         DATA_NUM   = 14;
    localparam logic [7:0] FRAME_HEAD = 8'h55;
    localparam logic [7:0] FRAME_TAIL = 8'hAA;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } tx_state_e;

endpackage

// File: rtl/uart_mult_byte_tx_byte.sv
// Single-byte UART serialiser: start bit, 8 data bits LSB first, stop bit.
// A start request in the last stop-bit cycle chains the next byte with no gap.
module uart_byte_tx
    import uart_mult_byte_tx_pkg::*;
#(
    parameter int BPS_CNT = 434
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       busy,
    output logic       done,
    output logic       stop_end
);

    localparam logic [15:0] BIT_LAST = 16'(BPS_CNT - 1);

    tx_state_e   state, state_nxt;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  shreg;
    logic        bit_end, txd_nxt;

    assign bit_end  = (baud_cnt == BIT_LAST);
    assign busy     = (state == START) || (state == DATA) || (state == STOP);
    assign done     = (state == DONE);
    assign stop_end = (state == STOP) && bit_end;

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        txd_nxt     = 1'b1;
        case (state)
            IDLE:    if (start) state_nxt = START;
            START:   if (bit_end) state_nxt = DATA;
            DATA: begin
                if (bit_end) begin
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = STOP;
                end
            end
            STOP:    if (bit_end) state_nxt = start ? START : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Line level is computed one cycle ahead so txd itself is a flop.
        case (state_nxt)
            START:   txd_nxt = 1'b0;
            DATA:    txd_nxt = shreg[bit_cnt_nxt];
            default: txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            txd      <= 1'b1;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            txd      <= txd_nxt;
            baud_cnt <= (busy && !bit_end) ? baud_cnt + 16'd1 : 16'd0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (state_nxt == START && state != START) shreg <= data;
    end

endmodule

// File: rtl/uart_mult_byte_tx.sv
// Frame transmitter: latches a 12-byte payload, wraps it in header/tail bytes
// and streams the 14 bytes back-to-back through uart_byte_tx.
module uart_mult_byte_tx
    import uart_mult_byte_tx_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       send_req,
    input  logic [7:0] tx_data0,
    input  logic [7:0] tx_data1,
    input  logic [7:0] tx_data2,
    input  logic [7:0] tx_data3,
    input  logic [7:0] tx_data4,
    input  logic [7:0] tx_data5,
    input  logic [7:0] tx_data6,
    input  logic [7:0] tx_data7,
    input  logic [7:0] tx_data8,
    input  logic [7:0] tx_data9,
    input  logic [7:0] tx_data10,
    input  logic [7:0] tx_data11,
    output logic       uart_txd,
    output logic       tx_busy,
    output logic       pack_done,
    output logic [3:0] byte_idx
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;

    logic [7:0] frame_buf [DATA_NUM];
    logic [7:0] byte_data;
    logic [3:0] next_idx;
    logic       accept, go_p1, last_byte, byte_start, stop_end;

    // go_p1 covers the cycle between latching and the first start bit, so a
    // second request there is dropped as well.
    assign accept     = send_req && !tx_busy && !go_p1;
    assign last_byte  = (byte_idx == 4'(DATA_NUM - 1));
    assign next_idx   = last_byte ? 4'd0 : byte_idx + 4'd1;
    assign byte_start = go_p1 || (stop_end && !last_byte);
    assign byte_data  = go_p1 ? frame_buf[0] : frame_buf[next_idx];

    always_ff @(posedge sys_clk) begin
        if (accept) begin
            frame_buf[0]  <= FRAME_HEAD;
            frame_buf[1]  <= tx_data0;
            frame_buf[2]  <= tx_data1;
            frame_buf[3]  <= tx_data2;
            frame_buf[4]  <= tx_data3;
            frame_buf[5]  <= tx_data4;
            frame_buf[6]  <= tx_data5;
            frame_buf[7]  <= tx_data6;
            frame_buf[8]  <= tx_data7;
            frame_buf[9]  <= tx_data8;
            frame_buf[10] <= tx_data9;
            frame_buf[11] <= tx_data10;
            frame_buf[12] <= tx_data11;
            frame_buf[13] <= FRAME_TAIL;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            go_p1    <= 1'b0;
            byte_idx <= '0;
        end else begin
            go_p1 <= accept;
            if (stop_end) byte_idx <= next_idx;
        end
    end

    uart_byte_tx #(
        .BPS_CNT (BPS_CNT)
    ) u_byte_tx (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (byte_start),
        .data      (byte_data),
        .txd       (uart_txd),
        .busy      (tx_busy),
        .done      (pack_done),
        .stop_end  (stop_end)
    );

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Bench for uart_mult_byte_tx: per-cycle frame model, serial decoder and
// directed checks on latency, completion timing, drops, reset and chaining.
module tb_uart_mult_byte_tx;

    localparam int CLK_FREQ  = 1_000_000;
    localparam int UART_BPS  = 90_000;
    localparam int B         = 11;          // 1_000_000 / 90_000, floored
    localparam int FRAME_CYC = 140 * B;     // 1540

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       send_req = 1'b0;
    logic [7:0] tx_data [12];
    logic       uart_txd, tx_busy, pack_done;
    logic [3:0] byte_idx;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pd_count = 0;
    int frame_err = 0;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc++;

    uart_mult_byte_tx #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .send_req(send_req),
        .tx_data0(tx_data[0]), .tx_data1(tx_data[1]), .tx_data2(tx_data[2]),
        .tx_data3(tx_data[3]), .tx_data4(tx_data[4]), .tx_data5(tx_data[5]),
        .tx_data6(tx_data[6]), .tx_data7(tx_data[7]), .tx_data8(tx_data[8]),
        .tx_data9(tx_data[9]), .tx_data10(tx_data[10]), .tx_data11(tx_data[11]),
        .uart_txd(uart_txd), .tx_busy(tx_busy), .pack_done(pack_done),
        .byte_idx(byte_idx)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: after an accepted request the frame occupies offsets 0..FRAME_CYC-1,
    // offset FRAME_CYC is the completion cycle.
    logic [7:0] m_bytes [14];
    bit m_active = 1'b0;
    int m_off = 0;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_active = 1'b0;
            m_off = 0;
        end else if ((!m_active || m_off == FRAME_CYC) && send_req) begin
            m_bytes[0] = 8'h55;
            for (int i = 0; i < 12; i++) m_bytes[i+1] = tx_data[i];
            m_bytes[13] = 8'hAA;
            m_active = 1'b1;
            m_off = -1;
        end else if (m_active) begin
            m_off++;
            if (m_off > FRAME_CYC) m_active = 1'b0;
        end
    end

    int   e_idx, e_bit;
    logic e_txd, e_busy, e_pd;
    always @(negedge sys_clk) begin
        e_txd = 1'b1; e_busy = 1'b0; e_pd = 1'b0; e_idx = 0;
        if (sys_rst_n && m_active && m_off >= 0) begin
            if (m_off < FRAME_CYC) begin
                e_busy = 1'b1;
                e_idx  = m_off / (10 * B);
                e_bit  = (m_off % (10 * B)) / B;
                if (e_bit == 0)      e_txd = 1'b0;
                else if (e_bit == 9) e_txd = 1'b1;
                else                 e_txd = m_bytes[e_idx][e_bit-1];
            end else begin
                e_pd = 1'b1;
            end
        end
        chk("model_txd", 32'(uart_txd), 32'(e_txd));
        chk("model_busy", 32'(tx_busy), 32'(e_busy));
        chk("model_pack_done", 32'(pack_done), 32'(e_pd));
        chk("model_byte_idx", 32'(byte_idx), 32'(e_idx));
        if (pack_done === 1'b1) pd_count++;
    end

    // Independent serial decoder sampling mid-bit.
    logic [7:0] rxq [$];
    logic [7:0] dec_sh;
    bit dec_busy = 1'b0;
    int dec_cnt = 0;
    int dec_k;
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            dec_busy = 1'b0;
        end else if (!dec_busy) begin
            if (uart_txd === 1'b0) begin
                dec_busy = 1'b1;
                dec_cnt = 0;
            end
        end else begin
            dec_cnt++;
            if (dec_cnt >= B/2 + B && (dec_cnt - B/2) % B == 0) begin
                dec_k = (dec_cnt - B/2) / B;
                if (dec_k <= 8) dec_sh[dec_k-1] = uart_txd;
                else begin
                    if (uart_txd !== 1'b1) frame_err++;
                    rxq.push_back(dec_sh);
                    dec_busy = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic set_payload(input logic [7:0] base);
        for (int i = 0; i < 12; i++) tx_data[i] = base + 8'(i);
    endtask

    task automatic send(output int t_req);
        send_req = 1'b1;
        tick(1);
        send_req = 1'b0;
        t_req = cyc;
    endtask

    task automatic wait_done(input string name, input int t_req, input int exp_lat);
        int n = 0;
        while (pack_done !== 1'b1 && n < 4000) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 4000) chk({name, "_timeout"}, 32'(n), 32'd0);
        else if (exp_lat > 0) chk({name, "_latency"}, 32'(cyc - t_req), 32'(exp_lat));
    endtask

    task automatic check_frame(input string name, input logic [7:0] base);
        logic [7:0] exp;
        chk({name, "_rx_count"}, 32'(rxq.size() >= 14), 32'd1);
        for (int i = 0; i < 14; i++) begin
            exp = (i == 0) ? 8'h55 : (i == 13) ? 8'hAA : base + 8'(i - 1);
            if (rxq.size() > 0) chk($sformatf("%s_byte%0d", name, i), 32'(rxq.pop_front()), 32'(exp));
        end
    endtask

    int t0;
    initial begin
        set_payload(8'h01);
        tick(3);
        chk("rst_txd", 32'(uart_txd), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_pack_done", 32'(pack_done), 32'd0);
        chk("rst_byte_idx", 32'(byte_idx), 32'd0);
        sys_rst_n = 1'b1;
        tick(3);

        // Basic frame 55 01..0C AA, completion at N+1+1540
        send(t0);
        chk("lat0_txd", 32'(uart_txd), 32'd1);
        chk("lat0_busy", 32'(tx_busy), 32'd0);
        tick(1);
        chk("lat1_txd", 32'(uart_txd), 32'd0);
        chk("lat1_busy", 32'(tx_busy), 32'd1);
        chk("lat1_idx", 32'(byte_idx), 32'd0);
        wait_done("A", t0, 1541);
        tick(2);
        chk("A_pd_count", 32'(pd_count), 32'd1);
        if (rxq.size() >= 14) begin
            chk("A_lit_byte6", 32'(rxq[6]), 32'h06);
            chk("A_lit_tail", 32'(rxq[13]), 32'hAA);
        end
        check_frame("A", 8'h01);

        // Payload change and repeated request mid-frame are ignored
        set_payload(8'hA0);
        send(t0);
        tick(9);
        for (int i = 0; i < 12; i++) tx_data[i] = 8'hFF;
        tick(490);
        send_req = 1'b1;
        tick(1);
        send_req = 1'b0;
        wait_done("B", t0, 1541);
        tick(2);
        chk("B_pd_count", 32'(pd_count), 32'd2);
        check_frame("B", 8'hA0);

        // Asynchronous reset during byte 6
        set_payload(8'h10);
        send(t0);
        tick(1 + 6 * 10 * B + 3 * B - 1);
        chk("C_pre_idx", 32'(byte_idx), 32'd6);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("C_rst_txd", 32'(uart_txd), 32'd1);
        chk("C_rst_busy", 32'(tx_busy), 32'd0);
        chk("C_rst_idx", 32'(byte_idx), 32'd0);
        @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b1;
        tick(3);
        rxq.delete();
        chk("C_pd_count", 32'(pd_count), 32'd2);

        // Clean frame after reset
        set_payload(8'h20);
        send(t0);
        wait_done("D", t0, 1541);
        tick(2);
        check_frame("D", 8'h20);

        // Request on the pack_done cycle chains a second frame
        set_payload(8'h30);
        send(t0);
        begin
            int n = 0;
            while (pack_done !== 1'b1 && n < 4000) begin
                tick(1);
                n++;
            end
            if (n >= 4000) chk("E_timeout", 32'(n), 32'd0);
        end
        set_payload(8'h40);
        send_req = 1'b1;
        tick(1);
        send_req = 1'b0;
        t0 = cyc;
        chk("E_gap_txd", 32'(uart_txd), 32'd1);
        tick(1);
        chk("E_start_txd", 32'(uart_txd), 32'd0);
        chk("E_start_busy", 32'(tx_busy), 32'd1);
        wait_done("E2", t0, 1541);
        tick(2);
        chk("E_pd_count", 32'(pd_count), 32'd5);
        check_frame("E1", 8'h30);
        check_frame("E2", 8'h40);
        chk("frame_err", 32'(frame_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
